// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment frame reader.
// SEG_BLANK is only decoded as a digit when SEG7_RDR_BLANK_EN is defined.
package seg7_pkg;

    // Segment patterns: bit 6 = A down to bit 0 = G, active-high
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic {
        SYNC    = 1'b0,
        COLLECT = 1'b1
    } rdr_state_t;

    typedef struct packed {
        logic       err;
        logic [3:0] digit;
    } seg7_dec_t;

endpackage

// File: rtl/seg7_pattern_dec.sv
// Combinational segment pattern to BCD digit decoder with invalid flag.
// SEG7_RDR_BLANK_EN: decode the blank pattern as digit 0 without an error.
import seg7_pkg::*;

module seg7_pattern_dec (
    input  logic [6:0] i_pattern,
    output seg7_dec_t  o_dec_c
);

    always_comb begin
        o_dec_c = '{err: 1'b0, digit: 4'd0};
        case (i_pattern)
            SEG_0:     o_dec_c.digit = 4'd0;
            SEG_1:     o_dec_c.digit = 4'd1;
            SEG_2:     o_dec_c.digit = 4'd2;
            SEG_3:     o_dec_c.digit = 4'd3;
            SEG_4:     o_dec_c.digit = 4'd4;
            SEG_5:     o_dec_c.digit = 4'd5;
            SEG_6:     o_dec_c.digit = 4'd6;
            SEG_7:     o_dec_c.digit = 4'd7;
            SEG_8:     o_dec_c.digit = 4'd8;
            SEG_9:     o_dec_c.digit = 4'd9;
`ifdef SEG7_RDR_BLANK_EN
            SEG_BLANK: o_dec_c.digit = 4'd0;
`else
            SEG_BLANK: o_dec_c = '{err: 1'b1, digit: BCD_INVALID};
`endif
            default:   o_dec_c = '{err: 1'b1, digit: BCD_INVALID};
        endcase
    end

endmodule

// File: rtl/seg7_frame_reader.sv
// Samples a multiplexed 7-segment bus, filters glitches and assembles BCD frames.
// Blank-digit handling is selected by SEG7_RDR_BLANK_EN inside seg7_pattern_dec.
import seg7_pkg::*;

module seg7_frame_reader #(
    parameter int unsigned N_DIGITS   = 4,
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic [N_DIGITS-1:0]   dig_sel,
    output logic [4*N_DIGITS-1:0] bcd_out,
    output logic [N_DIGITS-1:0]   err_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  ovr,
    output logic                  seq_err
);

    localparam int unsigned SAMPLE_W = N_DIGITS + 7;
    localparam int unsigned CNT_W    = $clog2(STABLE_CYC + 1);
    localparam int unsigned IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned BCD_W    = 4 * N_DIGITS;

    logic [SAMPLE_W-1:0] r_sync1, r_sync2, r_prev;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_armed;
    rdr_state_t          r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_next_idx, w_idx_nxt;
    logic [BCD_W-1:0]    r_shadow_bcd, r_bcd_out, w_frame_bcd;
    logic [N_DIGITS-1:0] r_shadow_err, r_err_out, w_frame_err;
    logic                r_out_valid, r_ovr, r_seq_err;

    logic [N_DIGITS-1:0] w_sel;
    logic [6:0]          w_pat;
    logic                w_changed, w_accept;
    logic [IDX_W-1:0]    w_idx;
    seg7_dec_t           w_dec;
    logic                w_shadow_we, w_frame_done, w_seq_err;

    assign w_sel     = r_sync2[SAMPLE_W-1:7];
    assign w_pat     = r_sync2[6:0];
    assign w_changed = (r_sync2 != r_prev);
    assign w_accept  = !w_changed && r_armed && $onehot(w_sel)
                       && (r_cnt == CNT_W'(STABLE_CYC - 1));

    // Two-flop synchroniser plus stability counter and re-arm flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= {dig_sel, seg};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (w_changed) begin
                r_cnt   <= '0;
                r_armed <= 1'b1;
            end else begin
                if (r_cnt != CNT_W'(STABLE_CYC))
                    r_cnt <= r_cnt + CNT_W'(1);
                if (w_accept)
                    r_armed <= 1'b0;
            end
        end
    end

    always_comb begin
        w_idx = '0;
        for (int k = 0; k < int'(N_DIGITS); k++)
            if (w_sel[k]) w_idx = IDX_W'(k);
    end

    seg7_pattern_dec u_dec (
        .i_pattern (w_pat),
        .o_dec_c   (w_dec)
    );

    // Shadow contents with the accepted digit merged in
    always_comb begin
        w_frame_bcd = r_shadow_bcd;
        w_frame_err = r_shadow_err;
        w_frame_bcd[4*w_idx +: 4] = w_dec.digit;
        w_frame_err[w_idx]        = w_dec.err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= SYNC;
            r_next_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_next_idx <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_next_idx;
        w_shadow_we  = 1'b0;
        w_frame_done = 1'b0;
        w_seq_err    = 1'b0;
        if (w_accept) begin
            case (r_state)
                SYNC: begin
                    if (w_idx == '0) begin
                        w_shadow_we = 1'b1;
                        w_state_nxt = COLLECT;
                        w_idx_nxt   = IDX_W'(1);
                    end
                end
                COLLECT: begin
                    if (w_idx == r_next_idx) begin
                        w_shadow_we = 1'b1;
                        if (r_next_idx == IDX_W'(N_DIGITS - 1)) begin
                            w_frame_done = 1'b1;
                            w_state_nxt  = SYNC;
                        end else begin
                            w_idx_nxt = r_next_idx + IDX_W'(1);
                        end
                    end else begin
                        // Out-of-order strobe: a fresh digit 0 restarts the frame
                        w_seq_err = 1'b1;
                        if (w_idx == '0) begin
                            w_shadow_we = 1'b1;
                            w_idx_nxt   = IDX_W'(1);
                        end else begin
                            w_state_nxt = SYNC;
                        end
                    end
                end
                default: w_state_nxt = SYNC;
            endcase
        end
    end

    // Shadow digits and the output register with overrun handling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_bcd <= '0;
            r_shadow_err <= '0;
            r_bcd_out    <= '0;
            r_err_out    <= '0;
            r_out_valid  <= 1'b0;
            r_ovr        <= 1'b0;
            r_seq_err    <= 1'b0;
        end else begin
            r_ovr     <= 1'b0;
            r_seq_err <= w_seq_err;
            if (w_shadow_we) begin
                r_shadow_bcd <= w_frame_bcd;
                r_shadow_err <= w_frame_err;
            end
            if (w_frame_done) begin
                if (!r_out_valid || out_ready) begin
                    r_bcd_out   <= w_frame_bcd;
                    r_err_out   <= w_frame_err;
                    r_out_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bcd_out   = r_bcd_out;
    assign err_out   = r_err_out;
    assign out_valid = r_out_valid;
    assign ovr       = r_ovr;
    assign seq_err   = r_seq_err;

endmodule

// File: tb/tb_seg7_frame_reader.sv
// Directed bench for seg7_frame_reader: frame table plus glitch, order, backpressure and reset cases.
module tb_seg7_frame_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;
    logic [15:0] bcd_out;
    logic [3:0]  err_out;
    logic        out_valid;
    logic        out_ready;
    logic        ovr;
    logic        seq_err;

    seg7_frame_reader #(.N_DIGITS(4), .STABLE_CYC(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg       (seg),
        .dig_sel   (dig_sel),
        .bcd_out   (bcd_out),
        .err_out   (err_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovr       (ovr),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][6:0] pat;
        logic [15:0]     exp_bcd;
        logic [3:0]      exp_err;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Passive monitor, sampled on the falling edge
    int          n_vcyc = 0;
    int          n_ovr  = 0;
    int          n_seq  = 0;
    logic [19:0] cap_q[$];

    always @(negedge clk) begin
        if (out_valid) n_vcyc++;
        if (out_valid && out_ready) cap_q.push_back({err_out, bcd_out});
        if (ovr) n_ovr++;
        if (seq_err) n_seq++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_digit(input int k, input logic [6:0] p, input int cyc);
        dig_sel = 4'(1 << k);
        seg     = p;
        tick(cyc);
    endtask

    task automatic go_idle();
        dig_sel = 4'd0;
        seg     = 7'h00;
        tick(10);
    endtask

    task automatic send_frame(input logic [3:0][6:0] pat);
        for (int k = 0; k < 4; k++) drive_digit(k, pat[k], 10);
        go_idle();
    endtask

    vec_t vecs[5];
    logic [3:0][6:0] f1234, f5678, f9012, fblank;
    logic [15:0] blank_bcd;
    logic [3:0]  blank_err;
    int base_cap, base_v, base_ovr, base_seq;

    task automatic snap();
        base_cap = cap_q.size();
        base_v   = n_vcyc;
        base_ovr = n_ovr;
        base_seq = n_seq;
    endtask

    initial begin
        f1234 = {7'h30, 7'h6D, 7'h79, 7'h33};
        f5678 = {7'h5B, 7'h5F, 7'h70, 7'h7F};
        f9012 = {7'h7B, 7'h7E, 7'h30, 7'h6D};
        fblank = {7'h00, 7'h6D, 7'h79, 7'h33};
`ifdef SEG7_RDR_BLANK_EN
        blank_bcd = 16'h0234;
        blank_err = 4'b0000;
`else
        blank_bcd = 16'hF234;
        blank_err = 4'b1000;
`endif
        vecs[0].pat = f1234;                                  vecs[0].exp_bcd = 16'h1234; vecs[0].exp_err = 4'b0000;
        vecs[1].pat = {7'h30, 7'h6D, 7'h7C, 7'h33};           vecs[1].exp_bcd = 16'h12F4; vecs[1].exp_err = 4'b0010;
        vecs[2].pat = f5678;                                  vecs[2].exp_bcd = 16'h5678; vecs[2].exp_err = 4'b0000;
        vecs[3].pat = {7'h7E, 7'h7E, 7'h7E, 7'h7E};           vecs[3].exp_bcd = 16'h0000; vecs[3].exp_err = 4'b0000;
        vecs[4].pat = {7'h40, 7'h02, 7'h7D, 7'h01};           vecs[4].exp_bcd = 16'hFFFF; vecs[4].exp_err = 4'b1111;

        rst_n = 1'b0; seg = 7'h00; dig_sel = 4'd0; out_ready = 1'b1;
        tick(3);
        check("reset bcd_out", 32'(bcd_out), 32'h0);
        check("reset err_out", 32'(err_out), 32'h0);
        check("reset out_valid", 32'(out_valid), 32'h0);
        check("reset ovr", 32'(ovr), 32'h0);
        check("reset seq_err", 32'(seq_err), 32'h0);
        rst_n = 1'b1;
        tick(3);

        // Table-driven clean frames with out_ready held high
        for (int v = 0; v < 5; v++) begin
            snap();
            send_frame(vecs[v].pat);
            check($sformatf("vec%0d frames", v), 32'(cap_q.size() - base_cap), 32'd1);
            if (cap_q.size() > base_cap) begin
                check($sformatf("vec%0d bcd", v), 32'(cap_q[base_cap][15:0]), 32'(vecs[v].exp_bcd));
                check($sformatf("vec%0d err", v), 32'(cap_q[base_cap][19:16]), 32'(vecs[v].exp_err));
            end
            check($sformatf("vec%0d valid cycles", v), 32'(n_vcyc - base_v), 32'd1);
            check($sformatf("vec%0d seq_err", v), 32'(n_seq - base_seq), 32'd0);
            check($sformatf("vec%0d ovr", v), 32'(n_ovr - base_ovr), 32'd0);
        end

        // Short glitch on digit 2 before its pattern settles
        snap();
        drive_digit(0, 7'h33, 10);
        drive_digit(1, 7'h79, 10);
        drive_digit(2, 7'h6D, 1);
        drive_digit(2, 7'h7F, 2);
        drive_digit(2, 7'h6D, 7);
        drive_digit(3, 7'h30, 10);
        go_idle();
        check("glitch frames", 32'(cap_q.size() - base_cap), 32'd1);
        if (cap_q.size() > base_cap)
            check("glitch bcd", 32'(cap_q[base_cap]), 32'h01234);
        check("glitch seq_err", 32'(n_seq - base_seq), 32'd0);

        // Out-of-order strobe 0 then 2
        snap();
        drive_digit(0, 7'h33, 10);
        drive_digit(2, 7'h6D, 10);
        go_idle();
        check("order seq_err pulses", 32'(n_seq - base_seq), 32'd1);
        check("order no frame", 32'(cap_q.size() - base_cap), 32'd0);
        check("order valid low", 32'(out_valid), 32'd0);
        send_frame(f1234);
        check("order recovery frames", 32'(cap_q.size() - base_cap), 32'd1);
        if (cap_q.size() > base_cap)
            check("order recovery bcd", 32'(cap_q[base_cap]), 32'h01234);

        // Backpressure: second frame dropped, first held stable
        snap();
        out_ready = 1'b0;
        send_frame(f1234);
        check("bp first valid", 32'(out_valid), 32'd1);
        check("bp first bcd", 32'(bcd_out), 32'h1234);
        check("bp first ovr", 32'(n_ovr - base_ovr), 32'd0);
        send_frame(f5678);
        check("bp ovr pulses", 32'(n_ovr - base_ovr), 32'd1);
        check("bp held bcd", 32'(bcd_out), 32'h1234);
        check("bp held valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick(3);
        check("bp drained valid", 32'(out_valid), 32'd0);
        send_frame(f9012);
        check("bp consumed count", 32'(cap_q.size() - base_cap), 32'd2);
        if (cap_q.size() >= base_cap + 2) begin
            check("bp consumed first", 32'(cap_q[base_cap]), 32'h01234);
            check("bp consumed second", 32'(cap_q[base_cap + 1]), 32'h09012);
        end

        // Asynchronous reset mid-frame, then a frame without digit 0
        drive_digit(0, 7'h33, 10);
        drive_digit(1, 7'h79, 10);
        #2 rst_n = 1'b0;
        #1;
        check("midreset bcd_out", 32'(bcd_out), 32'h0);
        check("midreset err_out", 32'(err_out), 32'h0);
        check("midreset out_valid", 32'(out_valid), 32'h0);
        dig_sel = 4'd0; seg = 7'h00;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        snap();
        drive_digit(1, 7'h79, 10);
        drive_digit(2, 7'h6D, 10);
        drive_digit(3, 7'h30, 10);
        go_idle();
        check("postreset seq_err", 32'(n_seq - base_seq), 32'd0);
        check("postreset no frame", 32'(cap_q.size() - base_cap), 32'd0);
        send_frame(fblank);
        check("blank frames", 32'(cap_q.size() - base_cap), 32'd1);
        if (cap_q.size() > base_cap) begin
            check("blank bcd", 32'(cap_q[base_cap][15:0]), 32'(blank_bcd));
            check("blank err", 32'(cap_q[base_cap][19:16]), 32'(blank_err));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_frame_reader.md
Name: seg7_frame_reader

Overview:
- Reader side of the BCD-to-7-segment display path.
- Samples a multiplexed 7-segment display bus (segment lines plus one-hot digit strobes) and filters glitches.
- Decodes each segment pattern back to a BCD digit and assembles a full multi-digit frame.
- Presents each frame on a valid/ready output with per-digit invalid-pattern flags. Used for display loopback checking and for reading external panels.

Parameters:
- N_DIGITS, 4, number of multiplexed digits per frame (>=2).
- STABLE_CYC, 4, consecutive identical synchronised samples required before a strobe/pattern is accepted (>=1).

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- seg  in  7  segment lines, active-high; seg[6]=A down to seg[0]=G; asynchronous to clk.
- dig_sel  in  N_DIGITS  one-hot digit strobe; bit k = digit k (digit 0 least significant); asynchronous to clk.
- bcd_out  out  4*N_DIGITS  frame value, digit k in bits [4k+3:4k].
- err_out  out  N_DIGITS  per-digit flag: the pattern was not a valid code.
- out_valid  out  1  frame available.
- out_ready  in  1  consumer accepts the frame.
- ovr  out  1  one-cycle pulse: a completed frame was dropped.
- seq_err  out  1  one-cycle pulse: a strobe arrived out of order.

Behaviour:
- Reset values: bcd_out=0, err_out=0, out_valid=0, ovr=0, seq_err=0. FSM resets to SYNC. Stability counter, armed flag and shadow registers reset to 0.
- Synchroniser: two flops on {dig_sel, seg}.
- Stability filter:
  - Counter clears whenever the synchronised {dig_sel, seg} differs from the previous cycle; otherwise it increments, saturating at STABLE_CYC.
  - A sample is accepted on the cycle the counter reaches STABLE_CYC, only if dig_sel is exactly one-hot and armed=1. Acceptance clears armed.
  - armed sets again on any input change.
  - Zero or multi-hot dig_sel is never accepted.
  - Pin-to-accept latency is 2+STABLE_CYC cycles.
- Decode table (pattern -> digit): 0x7E->0, 0x30->1, 0x6D->2, 0x79->3, 0x33->4, 0x5B->5, 0x5F->6, 0x70->7, 0x7F->8, 0x7B->9.
  - Any other pattern decodes to 4'hF with the digit's error bit set.
- FSM:
  - SYNC: accept of digit 0 -> write shadow digit 0 and go to COLLECT with next=1. Accept of any other digit is ignored silently.
  - COLLECT, accepted index == next: write shadow; if next==N_DIGITS-1 the frame is complete and the FSM goes to SYNC, else next++.
  - COLLECT, accepted index != next: pulse seq_err and discard the partial frame. If the index is 0, restart COLLECT with next=1; otherwise go to SYNC.
- Output register:
  - On frame complete with out_valid=0 or (out_valid & out_ready): load bcd_out/err_out from shadow (including the final digit) and set out_valid on the next cycle.
  - On frame complete with out_valid & !out_ready: drop the new frame and pulse ovr. bcd_out/err_out stay stable.
  - out_valid clears on out_valid & out_ready unless a load occurs in the same cycle.
  - Collection continues regardless of backpressure.
- Simultaneous seq_err and frame completion cannot occur.
- rst_n assertion mid-frame discards all state immediately (asynchronous).

Optional Feature:
- SEG7_RDR_BLANK_EN defined: pattern 0x00 (blanked leading digit) decodes to 0 with no error bit.
- Undefined: 0x00 is invalid (4'hF, error bit set).

Decomposition:
- Package seg7_pkg holds:
  - segment-pattern localparams SEG_0..SEG_9 and SEG_BLANK;
  - BCD_INVALID = 4'hF;
  - the FSM state enum {SYNC, COLLECT}.
- Sub-module seg7_pattern_dec: combinational 7-bit pattern -> {err, 4-bit digit}, and the only place that uses the macro.
- Top-level block holds the synchroniser, filter, FSM, shadow registers and output register.

Test Plan (N_DIGITS=4, STABLE_CYC=4):
1. Strobes 0..3 with patterns 0x33, 0x79, 0x6D, 0x30, each held 10 cycles, out_ready=1 -> single frame bcd_out=16'h1234, err_out=4'b0000, out_valid high for 1 cycle.
2. Same frame but digit 1 pattern 0x7C -> bcd_out=16'h12F4, err_out=4'b0010.
3. 2-cycle glitch pattern 0x7F on digit 2 inside its 10-cycle dwell -> ignored; bcd_out=16'h1234; exactly one accept per dwell.
4. Strobe order 0, 2 -> seq_err pulse, no output. Next clean 0..3 frame -> bcd_out=16'h1234.
5. out_ready=0 across two frames, 16'h1234 then 16'h5678 -> first frame held stable, ovr pulses once. Raise out_ready, send 16'h9012 -> consumer sees 16'h1234 then 16'h9012.
6. rst_n low mid-frame, after digit 1 -> outputs 0 and FSM in SYNC. With SEG7_RDR_BLANK_EN, a digit 3 blank frame -> bcd_out=16'h0234, err_out=0; without the macro -> 16'hF234, err_out=4'b1000.
